// File: rtl/multu_hilo_ctrl_if.sv
// EX-stage bus between the pipeline control and the MULTU/HI/LO unit.
// The pipeline side is the master; the multiply unit is the slave.
interface multu_hilo_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             op_valid;
    logic [5:0]       funct;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output op_valid, funct, src_a, src_b,
        input  stall, busy, done, hi_out, lo_out
    );

    modport slave (
        input  op_valid, funct, src_a, src_b,
        output stall, busy, done, hi_out, lo_out
    );
endinterface

// File: rtl/multu_hilo_ctrl.sv
// Iterative shift-add MULTU sequencer and HI/LO register owner.
// Stalls MFHI/MFLO/MULTU in EX while a multiply is still in flight.
module multu_hilo_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    multu_hilo_ctrl_if.slave  bus
);
    localparam int unsigned PW = 2 * WIDTH + 1;

    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state, w_next_state;
    logic [WIDTH-1:0]   r_a, w_a_next;
    logic [PW-1:0]      r_prod, w_prod_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [WIDTH-1:0]   r_hi, w_hi_next;
    logic [WIDTH-1:0]   r_lo, w_lo_next;
    logic               r_busy, w_busy_next;
    logic               r_done, w_done_next;

    logic [WIDTH:0]     w_sum;
    logic [PW-1:0]      w_step;
    logic               w_is_multu;
    logic               w_hilo_op;

    assign w_is_multu = bus.op_valid && (bus.funct == FUNCT_MULTU);
    assign w_hilo_op  = (bus.funct == FUNCT_MULTU) || (bus.funct == FUNCT_MFHI) ||
                        (bus.funct == FUNCT_MFLO);

    // One partial product: conditionally add multiplicand to the upper half, then shift right.
    assign w_sum  = r_prod[PW-1:WIDTH] + (WIDTH+1)'(r_a);
    assign w_step = r_prod[0] ? (PW'({w_sum, r_prod[WIDTH-1:0]}) >> 1) : (r_prod >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_a     <= w_a_next;
            r_prod  <= w_prod_next;
            r_cnt   <= w_cnt_next;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_a_next     = r_a;
        w_prod_next  = r_prod;
        w_cnt_next   = r_cnt;
        w_hi_next    = r_hi;
        w_lo_next    = r_lo;
        w_done_next  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_is_multu) begin
                    w_next_state = S_BUSY;
                    w_a_next     = bus.src_a;
                    w_prod_next  = PW'(bus.src_b);
                    w_cnt_next   = '0;
                end
            end
            S_BUSY: begin
                w_prod_next = w_step;
                w_cnt_next  = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_hi_next    = w_step[2*WIDTH-1:WIDTH];
                    w_lo_next    = w_step[WIDTH-1:0];
                    w_done_next  = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase

        w_busy_next = (w_next_state == S_BUSY);
    end

    // Only HI/LO consumers and a competing MULTU must wait for the running multiply.
    assign bus.stall  = bus.op_valid && (r_state == S_BUSY) && w_hilo_op;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.hi_out = r_hi;
    assign bus.lo_out = r_lo;

endmodule
